seg7_scan_driver: RTL

//  Consumes the square wave from the divider stage (refresh_in) and time-multiplexes a
//  4-digit common-anode 7-segment display. Each sampled rising edge of refresh_in

---
 rtl/seg7_scan_driver_pkg.sv | 43 ++++
 rtl/seg7_scan_driver_if.sv | 28 ++
 rtl/seg7_scan_driver_hex_to_seg7.sv | 32 +++
 rtl/seg7_scan_driver.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants, state encoding and helpers for the 4-digit 7-segment scan driver.
// All segment/anode encodings here are active-low.
package seg7_scan_driver_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // {g,f,e,d,c,b,a} patterns for hex digits 0..F
  localparam logic [6:0] HEX_0 = 7'b1000000;
  localparam logic [6:0] HEX_1 = 7'b1111001;
  localparam logic [6:0] HEX_2 = 7'b0100100;
  localparam logic [6:0] HEX_3 = 7'b0110000;
  localparam logic [6:0] HEX_4 = 7'b0011001;
  localparam logic [6:0] HEX_5 = 7'b0010010;
  localparam logic [6:0] HEX_6 = 7'b0000010;
  localparam logic [6:0] HEX_7 = 7'b1111000;
  localparam logic [6:0] HEX_8 = 7'b0000000;
  localparam logic [6:0] HEX_9 = 7'b0010000;
  localparam logic [6:0] HEX_A = 7'b0001000;
  localparam logic [6:0] HEX_B = 7'b0000011;
  localparam logic [6:0] HEX_C = 7'b1000110;
  localparam logic [6:0] HEX_D = 7'b0100001;
  localparam logic [6:0] HEX_E = 7'b0000110;
  localparam logic [6:0] HEX_F = 7'b0001110;

  // Snapshot of the display inputs taken once per frame.
  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  digit_en;
    logic [3:0]  dp;
    logic [3:0]  blink_en;
  } frame_t;

  function automatic logic [3:0] an_select(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle: refresh wave, digit data/controls in, segment/anode drive out.
// The driver module uses the slave view; the stimulus/host side uses master.
interface seg7_scan_driver_if;
  import seg7_scan_driver_pkg::*;

  logic        refresh_in;
  logic [15:0] value;
  logic [3:0]  digit_en;
  logic [3:0]  dp;
  logic [3:0]  blink_en;
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  an;
  logic        frame_done;
  scan_state_t dbg_state;
  logic [1:0]  dbg_idx;

  modport master (
    output refresh_in, value, digit_en, dp, blink_en,
    input  seg, dp_n, an, frame_done, dbg_state, dbg_idx
  );

  modport slave (
    input  refresh_in, value, digit_en, dp, blink_en,
    output seg, dp_n, an, frame_done, dbg_state, dbg_idx
  );

endinterface

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// Combinational hex nibble to active-low {g,f,e,d,c,b,a} segment decoder.
module hex_to_seg7
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_BLANK;
    case (hex)
      4'h0:    seg_n = HEX_0;
      4'h1:    seg_n = HEX_1;
      4'h2:    seg_n = HEX_2;
      4'h3:    seg_n = HEX_3;
      4'h4:    seg_n = HEX_4;
      4'h5:    seg_n = HEX_5;
      4'h6:    seg_n = HEX_6;
      4'h7:    seg_n = HEX_7;
      4'h8:    seg_n = HEX_8;
      4'h9:    seg_n = HEX_9;
      4'hA:    seg_n = HEX_A;
      4'hB:    seg_n = HEX_B;
      4'hC:    seg_n = HEX_C;
      4'hD:    seg_n = HEX_D;
      4'hE:    seg_n = HEX_E;
      4'hF:    seg_n = HEX_F;
      default: seg_n = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit common-anode display driver: one digit per refresh edge,
// optional all-off gap between digits, per-frame input latch, per-digit enable/blink.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic              clock,
  input  logic              reset,
  seg7_scan_driver_if.slave bus
);

  localparam int GAP_W = (BLANK_CYCLES > 2) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD =
    (BLANK_CYCLES == 0) ? '0 : GAP_W'(BLANK_CYCLES - 1);
  localparam int CNT_W = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [2:0]       sync_q;
  logic             tick;
  scan_state_t      state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  frame_t           frame_q, frame_d, frame_in;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             phase_q, phase_d;
  logic             enter_show;
  logic             leave_last;
  logic             lit;
  logic [3:0]       nibble;
  logic [6:0]       dec_seg;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dpn_q, dpn_d;
  logic             fd_q;

  // refresh_in is asynchronous: two flops to settle, third to find the rising edge.
  always_ff @(posedge clock) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[1:0], bus.refresh_in};
  end

  assign tick = sync_q[1] & ~sync_q[2];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_BLANK;
      idx_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
    end
  end

  // Ticks arriving while blanking are deliberately discarded, not queued.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    enter_show = 1'b0;
    leave_last = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (gap_q == '0) begin
          state_d    = ST_SHOW;
          enter_show = 1'b1;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      ST_SHOW: begin
        if (tick) begin
          idx_d      = idx_q + 2'd1;
          leave_last = (idx_q == 2'd3);
          if (BLANK_CYCLES == 0) begin
            state_d    = ST_SHOW;
            enter_show = 1'b1;
          end else begin
            state_d = ST_BLANK;
            gap_d   = GAP_LOAD;
          end
        end
      end
      default: state_d = ST_BLANK;
    endcase
  end

  assign frame_in = '{value:    bus.value,
                      digit_en: bus.digit_en,
                      dp:       bus.dp,
                      blink_en: bus.blink_en};

  assign frame_d = (enter_show && idx_d == 2'd0) ? frame_in : frame_q;

  always_ff @(posedge clock) begin
    if (reset) frame_q <= '0;
    else       frame_q <= frame_d;
  end

  // Blink phase advances on the same edge the frame ends, so the next frame's
  // digit 0 already sees the new phase even with no blank gap.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (leave_last) begin
      if (blink_cnt_q == CNT_LAST) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign nibble = frame_d.value[{idx_d, 2'b00} +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .hex   (nibble),
    .seg_n (dec_seg)
  );

  // Outputs are computed from next-state values so they switch on the state edge.
  always_comb begin
    an_d  = an_q;
    seg_d = seg_q;
    dpn_d = dpn_q;
    lit   = 1'b0;
    if (enter_show) begin
      lit   = frame_d.digit_en[idx_d] & ~(frame_d.blink_en[idx_d] & phase_d);
      an_d  = lit ? an_select(idx_d) : AN_OFF;
      seg_d = lit ? dec_seg : SEG_BLANK;
      dpn_d = lit ? ~frame_d.dp[idx_d] : 1'b1;
    end else if (state_d == ST_BLANK) begin
      an_d  = AN_OFF;
      seg_d = SEG_BLANK;
      dpn_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      an_q  <= AN_OFF;
      seg_q <= SEG_BLANK;
      dpn_q <= 1'b1;
      fd_q  <= 1'b0;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dpn_q <= dpn_d;
      fd_q  <= leave_last;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp_n       = dpn_q;
  assign bus.frame_done = fd_q;
  assign bus.dbg_state  = state_q;
  assign bus.dbg_idx    = idx_q;

endmodule
